// File: rtl/rle_pkg.sv
// rle_pkg: widths and FSM state encoding shared by the run-length encoder and decoder
package rle_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int COUNT_WIDTH_DEF = 8;
  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;
endpackage

// File: rtl/rle_run_counter.sv
// rle_run_counter: loadable down-counter tracking symbols left in the current run
module rle_run_counter
  import rle_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   dec,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   is_zero
);
  assign is_zero = count == '0;
  // load wins over dec so a new run can replace the finishing one on the same edge
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (dec && !is_zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/rle_decoder.sv
// rle_decoder: expands (symbol, count) tokens into runs of count+1 symbols, one per cycle
module rle_decoder
  import rle_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_symbol,
  input  logic [COUNT_WIDTH-1:0] in_count,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last
);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] run_sym;
  logic [COUNT_WIDTH-1:0] remaining;
  logic run_last, rem_zero, accept, xfer;
  rle_run_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .load_value(in_count),
    .dec(xfer),
    .count(remaining),
    .is_zero(rem_zero)
  );
  // lookahead ready lets the next token load on the edge that drains the current run
  always_comb begin
    in_ready = !reset && (state == IDLE || (rem_zero && out_ready));
    out_valid = state == EMIT;
    out_data = run_sym;
    out_last = run_last && rem_zero && out_valid;
    accept = in_valid && in_ready;
    xfer = out_valid && out_ready;
    state_nx = accept ? EMIT : (xfer && rem_zero) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      run_sym <= '0;
      run_last <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        run_sym <= in_symbol;
        run_last <= in_last;
      end
    end
  end
  zero_flag_consistent: assert property (@(posedge clk) rem_zero == (remaining == '0));
endmodule

// File: tb/tb_rle_decoder.sv
// tb_rle_decoder: directed vector table plus long-run, reset and random scoreboard sequences
module tb_rle_decoder;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0, out_valid, out_ready = 1'b0, out_last;
  logic [7:0] in_symbol = 8'h00, in_count = 8'h00, out_data;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  rle_decoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_symbol(in_symbol),
    .in_count(in_count), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  typedef struct {
    logic iv; logic [7:0] sym; logic [7:0] cnt; logic lst; logic ord;
    logic e_ir; logic e_ov; logic [7:0] e_od; logic e_ol;
  } vec_t;
  vec_t vt[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] sym, input logic [7:0] cnt,
                       input logic lst, input logic ord);
    in_valid = iv; in_symbol = sym; in_count = cnt; in_last = lst; out_ready = ord;
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] sym, input logic [7:0] cnt,
                              input logic lst, input logic ord, input logic e_ir,
                              input logic e_ov, input logic [7:0] e_od, input logic e_ol);
    vec_t v;
    v.iv = iv; v.sym = sym; v.cnt = cnt; v.lst = lst; v.ord = ord;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
    return v;
  endfunction

  initial begin
    int nx, nl, li, bad;
    bit done;
    logic [8:0] q[$];
    logic [8:0] e;
    int toks_left, exp_total, got_total;
    bit pend;
    // single token, then back-to-back runs, then a stalled run
    vt[0]  = mk(1'b1, 8'h41, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    vt[1]  = mk(1'b0, 8'h41, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1);
    vt[2]  = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0);
    vt[3]  = mk(1'b1, 8'h10, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0);
    vt[4]  = mk(1'b1, 8'h20, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
    vt[5]  = mk(1'b1, 8'h20, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
    vt[6]  = mk(1'b1, 8'h20, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
    vt[7]  = mk(1'b1, 8'h20, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0);
    vt[8]  = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
    vt[9]  = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0);
    vt[10] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
    vt[11] = mk(1'b1, 8'h55, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
    vt[12] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    vt[13] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    vt[14] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    vt[15] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
    vt[16] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
    vt[17] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
    vt[18] = mk(1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0);

    @(negedge clk); #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    chk("post-rst out_valid", 32'(out_valid), 32'd0);
    chk("post-rst out_data", 32'(out_data), 32'd0);
    chk("post-rst out_last", 32'(out_last), 32'd0);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].sym, vt[i].cnt, vt[i].lst, vt[i].ord);
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(vt[i].e_od));
      chk($sformatf("row%0d out_last", i), 32'(out_last), 32'(vt[i].e_ol));
    end

    // maximum count: 256 symbols, last only on the final one
    @(negedge clk); drive(1'b1, 8'hFF, 8'd255, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 8'h00, 8'd0, 1'b0, 1'b1);
    nx = 0; nl = 0; li = 0; bad = 0; done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (out_valid) begin
        nx++;
        if (out_data !== 8'hFF) bad++;
        if (out_last) begin nl++; li = nx; end
        @(negedge clk);
      end else done = 1;
    end
    chk("max run transfers", 32'(nx), 32'd256);
    chk("max run bad data", 32'(bad), 32'd0);
    chk("max run last count", 32'(nl), 32'd1);
    chk("max run last index", 32'(li), 32'd256);

    // reset after 2 of 5 symbols
    @(negedge clk); drive(1'b1, 8'h33, 8'd4, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 8'h00, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk); reset = 1'b1; #1;
    chk("mid-rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    chk("mid-rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-rst out_data", 32'(out_data), 32'd0);
    chk("mid-rst in_ready after", 32'(in_ready), 32'd1);
    @(negedge clk); drive(1'b1, 8'h44, 8'd0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 8'h00, 8'd0, 1'b0, 1'b1);
    nx = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        nx++;
        if (out_data !== 8'h44) bad++;
      end
      @(negedge clk);
    end
    chk("after-rst transfers", 32'(nx), 32'd1);
    chk("after-rst bad data", 32'(bad), 32'd0);

    // random tokens and backpressure against a symbol scoreboard
    toks_left = 40; exp_total = 0; got_total = 0; pend = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (!pend && toks_left > 0 && $urandom_range(0, 3) != 0) begin
        pend = 1;
        in_symbol = 8'($urandom); in_count = 8'($urandom_range(0, 7)); in_last = 1'($urandom);
      end
      in_valid = pend;
      out_ready = $urandom_range(0, 2) != 0;
      #1;
      chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && out_ready) begin
        got_total++;
        if (q.size() == 0) chk("rnd unexpected symbol", 32'({out_last, out_data}), 32'h1FF);
        else begin
          e = q.pop_front();
          chk($sformatf("rnd%0d symbol", c), 32'({out_last, out_data}), 32'(e));
        end
      end
      if (in_valid && in_ready) begin
        for (int j = 0; j <= int'(in_count); j++) q.push_back({in_last && j == int'(in_count), in_symbol});
        exp_total += int'(in_count) + 1;
        pend = 0; toks_left--;
      end
      done = toks_left == 0 && !pend && q.size() == 0;
    end
    in_valid = 1'b0;
    chk("rnd total transfers", 32'(got_total), 32'(exp_total));
    chk("rnd drained", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rle_decoder.md
# rle_decoder

Streaming run-length decompressor: the decode side of the run-length compression path. It accepts (symbol, repeat-count) tokens on a valid/ready input stream and expands each token into a run of identical symbols on a valid/ready output stream, one symbol per cycle. It sits between the compressed-token FIFO and the downstream consumer of decompressed data. It sustains full throughput across token boundaries, with no bubble between runs.

## Interface
- DATA_WIDTH, 8, width of a decompressed symbol
- COUNT_WIDTH, 8, width of the repeat field; encodes run length minus one
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk
- in_valid  input  1  token present on in_symbol/in_count/in_last
- in_ready  output  1  decoder accepts the token this cycle
- in_symbol  input  DATA_WIDTH  symbol to repeat
- in_count  input  COUNT_WIDTH  run length minus one (0 = emit once)
- in_last  input  1  token is the final token of a block
- out_valid  output  1  out_data holds a valid symbol
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  DATA_WIDTH  decompressed symbol
- out_last  output  1  high on the final symbol of the final run of a block

## Operation
- States: IDLE (no run loaded) and EMIT (run loaded, symbols pending).
- Registers: run_sym (DATA_WIDTH), remaining (COUNT_WIDTH), run_last (1), state.
- Accept: a token is taken when in_valid && in_ready at a rising edge. The token loads run_sym=in_symbol, remaining=in_count, run_last=in_last, and the state becomes EMIT.
- in_ready = !reset && (state==IDLE || (state==EMIT && remaining==0 && out_ready)).
  - This lookahead lets the next token load on the same edge that transfers the last symbol of the current run.
- Outputs:
  - out_valid = (state==EMIT).
  - out_data = run_sym.
  - out_last = run_last && remaining==0 && state==EMIT.
- Transfer: each edge with out_valid && out_ready consumes one symbol.
  - If remaining>0, remaining decrements by 1.
  - If remaining==0 and no token is accepted, the state returns to IDLE.
  - If remaining==0 and a token is accepted, the new token loads and the state stays EMIT.
- A run of in_count=c produces exactly c+1 transfers. remaining never wraps: a decrement occurs only from a nonzero value.
- Stall: while out_valid && !out_ready, out_data, out_last and remaining hold, and in_ready is 0.
- Input protocol: the upstream holds in_valid and the token fields stable until accepted. The decoder ignores tokens while in_ready is 0.
- in_last only tags output. The decoder does not pause after a block; the next token may follow immediately.

## Timing
- Reset values (one edge with reset=1): state=IDLE, run_sym=0, remaining=0, run_last=0.
  - Hence out_valid=0, out_data=0, out_last=0.
  - in_ready=0 while reset is high, and 1 on the first cycle after reset.
- Latency: a token accepted at edge k drives out_valid=1 and out_data=in_symbol immediately after edge k. The first symbol transfers at edge k+1 at the earliest.
- Throughput: with out_ready held at 1 and tokens always available, out_valid stays 1 continuously; total output = sum of (count+1).
- Reset mid-run: the pending run is discarded. out_valid=0 after the reset edge. No partial state survives.
- Reset overrides any simultaneous accept or transfer.
- count=2^COUNT_WIDTH-1 yields 2^COUNT_WIDTH symbols with no overflow.

## Structure
- Shared package rle_pkg holds:
  - default DATA_WIDTH and COUNT_WIDTH constants, shared with the encoder;
  - the state encoding constants IDLE/EMIT.
- One sub-module: rle_run_counter, a COUNT_WIDTH down-counter.
  - Inputs: load, load_value, dec.
  - Outputs: count, is_zero.
  - Synchronous active-high reset to 0.
- The top level holds the FSM, the symbol/last registers and the handshake logic.

## Test plan
- Reset then a single token (sym=0x41, count=0, last=1), out_ready=1 -> exactly one transfer of 0x41 with out_last=1 at the first edge after acceptance; out_valid=0 afterwards.
- Token (0x10, count=3), then (0x20, count=1), back-to-back, out_ready=1 -> output sequence 10,10,10,10,20,20 with out_valid held high for 6 consecutive cycles. in_ready pulses on the 4th transfer edge.
- Token (0x55, count=2) with out_ready toggling 1,0,0,1,0,1 -> out_data held at 0x55 during stalls; exactly 3 transfers; in_ready=0 throughout the stalls.
- Token (0xFF, count=255, last=1) -> 256 transfers; out_last only on the 256th; remaining never wraps.
- Reset asserted after 2 of 5 symbols of run (0x33, count=4) -> out_valid=0 from the next cycle; a new token (0x44, count=0) after reset emits only 0x44.
- Random tokens with random out_ready compared against a scoreboard model -> symbol count equals sum(count+1), and order and out_last match.
